yam430_sequencer: RTL and testbench

- Instruction sequencer for the YAM430 datapath (register file, source/dest muxes, ALU, output demux).
- Fetches 16-bit opcodes from instruction memory over a req/ack handshake and holds the current opcode stable for the datapath.
- Drives the old-destination latch strobe, per-register write enables and the carry flag.
- Handles the non-ALU control opcodes: NOP, HALT, JMP, CLRC.

---
 rtl/yam430_sequencer_if.sv | 17 +
 rtl/yam430_sequencer.sv | 139 +++++++++++++
 tb/tb_yam430_sequencer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yam430_sequencer_if.sv
// Instruction-fetch bus between the YAM430 sequencer and instruction memory.
//   IReq  : fetch request, held high until IAck
//   IAddr : fetch address (sequencer program counter)
//   IData : 16-bit instruction word, valid while IAck=1
//   IAck  : fetch acknowledge from memory
// master = sequencer side, slave = memory side.
interface yam430_sequencer_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  IReq;
    logic [ADDR_WIDTH-1:0] IAddr;
    logic [15:0]           IData;
    logic                  IAck;

    modport master (output IReq, IAddr, input IData, IAck);
    modport slave  (input IReq, IAddr, output IData, IAck);
endinterface

// File: rtl/yam430_sequencer.sv
// YAM430 instruction sequencer: fetches opcodes over the ibus handshake,
// holds the current opcode for the datapath, and drives the old-destination
// latch strobe, one-hot register write enables and the carry flag.
// Executes the control opcodes NOP / HALT / JMP / CLRC itself.
// Ports:
//   Clk, Rst_n          clock, asynchronous active-low reset
//   Start_i             leave IDLE/HALTED and begin fetching
//   ibus                instruction fetch bus (master side)
//   Opcode_o            registered current instruction
//   AluSaveOldDest_o    one-cycle strobe latching the old destination value
//   RegWr_o             one-hot register write enable (WB cycle only)
//   CarryIn_o           registered carry flag to the ALU
//   CarryOut_i          ALU carry result, sampled in WB
//   Busy_o, Halted_o    status
//   Pc_o                program counter (same value as ibus.IAddr)
//
// state   | meaning
// IDLE    | after reset, waiting for Start
// FETCH   | IReq high with IAddr=Pc until IAck; capture opcode, Pc+1
// DECODE  | classify opcode; control ops complete here
// SAVE    | AluSaveOldDest strobe
// EXEC    | ALU settling cycle
// WB      | RegWr one-hot of dest, carry <= CarryOut
// HALTED  | stopped after HALT; Start resumes at current Pc
module yam430_sequencer #(
    parameter int REG_NUMBER = 16,
    parameter int SEL_WIDTH  = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Start_i,
    yam430_sequencer_if.master      ibus,
    output logic [15:0]             Opcode_o,
    output logic                    AluSaveOldDest_o,
    output logic [REG_NUMBER-1:0]   RegWr_o,
    output logic                    CarryIn_o,
    input  logic                    CarryOut_i,
    output logic                    Busy_o,
    output logic                    Halted_o,
    output logic [ADDR_WIDTH-1:0]   Pc_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_SAVE, S_EXEC, S_WB, S_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_HALT = 4'd1;
    localparam logic [3:0] OP_JMP  = 4'd2;
    localparam logic [3:0] OP_CLRC = 4'd3;

    // JMP target field is opcode[11:4]; narrower PCs take its low bits,
    // wider PCs zero-extend it.
    localparam int JMP_W = (ADDR_WIDTH < 8) ? ADDR_WIDTH : 8;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [15:0]            opcode_q, opcode_d;
    logic                   carry_q, carry_d;

    logic [3:0]             op;
    logic                   is_alu;
    logic [ADDR_WIDTH-1:0]  jmp_target;
    logic [REG_NUMBER-1:0]  dst_onehot;

    assign op         = opcode_q[15:12];
    assign is_alu     = op[3] | op[2];
    assign jmp_target = ADDR_WIDTH'(opcode_q[JMP_W+3:4]);

    always_comb begin
        dst_onehot = '0;
        dst_onehot[opcode_q[SEL_WIDTH-1:0]] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            opcode_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            carry_q  <= carry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        carry_d  = carry_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (Start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (ibus.IAck) begin
                    opcode_d = ibus.IData;
                    pc_d     = pc_q + ADDR_WIDTH'(1);
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_alu) begin
                    state_d = S_SAVE;
                end else begin
                    state_d = S_FETCH;
                    case (op)
                        OP_NOP:  ;
                        OP_HALT: state_d = S_HALTED;
                        OP_JMP:  pc_d = jmp_target;
                        OP_CLRC: carry_d = 1'b0;
                        default: ;
                    endcase
                end
            end
            S_SAVE:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB: begin
                carry_d = CarryOut_i;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every output comes from state or a register; none from an input.
    assign ibus.IReq        = (state_q == S_FETCH);
    assign ibus.IAddr       = pc_q;
    assign Pc_o             = pc_q;
    assign Opcode_o         = opcode_q;
    assign CarryIn_o        = carry_q;
    assign AluSaveOldDest_o = (state_q == S_SAVE);
    assign RegWr_o          = (state_q == S_WB) ? dst_onehot : '0;
    assign Halted_o         = (state_q == S_HALTED);
    assign Busy_o           = (state_q != S_IDLE) && (state_q != S_HALTED);
endmodule

// File: tb/tb_yam430_sequencer.sv
module tb_yam430_sequencer;
    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [15:0] Opcode;
    logic        AluSave;
    logic [15:0] RegWr;
    logic        CarryIn;
    logic        CarryOut;
    logic        Busy;
    logic        Halted;
    logic [7:0]  Pc;

    yam430_sequencer_if #(.ADDR_WIDTH(8)) ibus ();

    yam430_sequencer #(.REG_NUMBER(16), .SEL_WIDTH(4), .ADDR_WIDTH(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start_i(Start), .ibus(ibus),
        .Opcode_o(Opcode), .AluSaveOldDest_o(AluSave), .RegWr_o(RegWr),
        .CarryIn_o(CarryIn), .CarryOut_i(CarryOut), .Busy_o(Busy),
        .Halted_o(Halted), .Pc_o(Pc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // memory responder / stimulus knobs
    logic [15:0] mem [0:255];
    int  req_age, ack_delay, fixed_delay, co_mode;
    bit  ack_this, prev_ack, prev_rst;
    bit  start_noise, spur_ack, rand_delay, start_in_save;
    logic [15:0] prev_op;

    // ISA-level reference state
    logic [7:0] m_pc;
    logic       m_carry;

    // One clock: sample just after the edge, then drive this cycle's inputs.
    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
        checks++;
        if (!$onehot0(RegWr) || (AluSave && RegWr != 16'h0)) begin
            errors++;
            $display("FAIL strobe_exclusive cyc=%0d: RegWr=%h AluSave=%b, want onehot0 and not both", cyc, RegWr, AluSave);
        end
        if (Rst_n && prev_rst) begin
            checks++;
            if (Opcode !== prev_op && !prev_ack) begin
                errors++;
                $display("FAIL opcode_stable cyc=%0d: Opcode=%h was %h without an ack", cyc, Opcode, prev_op);
            end
        end
        prev_op  = Opcode;
        prev_rst = Rst_n;
        ack_this = 1'b0;
        if (ibus.IReq === 1'b1) begin
            if (req_age >= ack_delay) begin
                ibus.IAck  = 1'b1;
                ibus.IData = mem[ibus.IAddr];
                ack_this   = 1'b1;
                req_age    = 0;
                ack_delay  = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
            end else begin
                ibus.IAck  = 1'b0;
                ibus.IData = 16'($urandom);
                req_age++;
            end
        end else begin
            req_age    = 0;
            ibus.IAck  = spur_ack ? 1'($urandom_range(0, 1)) : 1'b0;
            ibus.IData = 16'($urandom);
        end
        prev_ack = ack_this;
        Start    = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        CarryOut = (co_mode == 0) ? 1'($urandom_range(0, 1)) : (co_mode == 1);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        Start = 1'b0;
        start_noise = 0; spur_ack = 0; start_in_save = 0; rand_delay = 0;
        co_mode = 0; fixed_delay = 2; ack_delay = 2;
        ibus.IAck = 1'b0;
        step();
        step();
        Rst_n = 1'b1;
        m_pc = 8'h00; m_carry = 1'b0;
        req_age = 0; ack_this = 0; prev_ack = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // Executes instructions at ISA level and checks each one's cycle timing.
    // Entry: DUT sampled in FETCH.  Exit: in FETCH again, or in HALTED.
    task automatic run_prog(input int n_instr, output bit halted);
        halted = 0;
        for (int i = 0; i < n_instr && !halted; i++) begin
            int guard;
            logic [15:0] w;
            logic [15:0] want_wr;
            guard = 0;
            while (!ack_this && guard < 20) begin
                checks++;
                if (ibus.IReq !== 1'b1 || ibus.IAddr !== m_pc) begin
                    errors++;
                    $display("FAIL fetch_hold: IReq=%b IAddr=%h, want 1 %h", ibus.IReq, ibus.IAddr, m_pc);
                end
                step();
                guard++;
            end
            checks++;
            if (!ack_this) begin
                errors++;
                $display("FAIL ack_timeout: no acked fetch at IAddr=%h within 20 cycles", m_pc);
                return;
            end
            if (ibus.IReq !== 1'b1 || ibus.IAddr !== m_pc) begin
                errors++;
                $display("FAIL fetch_ack: IReq=%b IAddr=%h, want 1 %h", ibus.IReq, ibus.IAddr, m_pc);
            end
            w = mem[m_pc];
            m_pc = m_pc + 8'd1;
            step();
            checks++;
            if (Opcode !== w || AluSave !== 1'b0 || RegWr !== 16'h0 || ibus.IReq !== 1'b0 ||
                Busy !== 1'b1 || CarryIn !== m_carry || Pc !== m_pc) begin
                errors++;
                $display("FAIL decode: Opcode=%h AluSave=%b RegWr=%h IReq=%b Busy=%b CarryIn=%b Pc=%h, want %h 0 0000 0 1 %b %h",
                         Opcode, AluSave, RegWr, ibus.IReq, Busy, CarryIn, Pc, w, m_carry, m_pc);
            end
            if (w[15] | w[14]) begin
                step();
                checks++;
                if (AluSave !== 1'b1 || RegWr !== 16'h0 || Busy !== 1'b1) begin
                    errors++;
                    $display("FAIL save: AluSave=%b RegWr=%h Busy=%b, want 1 0000 1", AluSave, RegWr, Busy);
                end
                if (start_in_save) Start = 1'b1;
                step();
                checks++;
                if (AluSave !== 1'b0 || RegWr !== 16'h0 || ibus.IReq !== 1'b0) begin
                    errors++;
                    $display("FAIL exec: AluSave=%b RegWr=%h IReq=%b, want 0 0000 0", AluSave, RegWr, ibus.IReq);
                end
                step();
                want_wr = 16'h1 << w[3:0];
                checks++;
                if (RegWr !== want_wr || AluSave !== 1'b0 || Opcode !== w) begin
                    errors++;
                    $display("FAIL writeback: RegWr=%h AluSave=%b Opcode=%h, want %h 0 %h", RegWr, AluSave, Opcode, want_wr, w);
                end
                m_carry = CarryOut;
                step();
                checks++;
                if (ibus.IReq !== 1'b1 || ibus.IAddr !== m_pc || CarryIn !== m_carry || RegWr !== 16'h0) begin
                    errors++;
                    $display("FAIL after_wb: IReq=%b IAddr=%h CarryIn=%b RegWr=%h, want 1 %h %b 0000",
                             ibus.IReq, ibus.IAddr, CarryIn, RegWr, m_pc, m_carry);
                end
            end else begin
                case (w[15:12])
                    4'd1: halted = 1;
                    4'd2: m_pc = w[11:4];
                    4'd3: m_carry = 1'b0;
                    default: ;
                endcase
                step();
                checks++;
                if (halted) begin
                    if (Halted !== 1'b1 || Busy !== 1'b0 || ibus.IReq !== 1'b0 || Pc !== m_pc || CarryIn !== m_carry) begin
                        errors++;
                        $display("FAIL halted: Halted=%b Busy=%b IReq=%b Pc=%h CarryIn=%b, want 1 0 0 %h %b",
                                 Halted, Busy, ibus.IReq, Pc, CarryIn, m_pc, m_carry);
                    end
                end else begin
                    if (ibus.IReq !== 1'b1 || ibus.IAddr !== m_pc || Pc !== m_pc || CarryIn !== m_carry ||
                        Busy !== 1'b1 || Halted !== 1'b0 || RegWr !== 16'h0 || AluSave !== 1'b0) begin
                        errors++;
                        $display("FAIL control_next: IReq=%b IAddr=%h Pc=%h CarryIn=%b Busy=%b Halted=%b RegWr=%h AluSave=%b, want 1 %h %h %b 1 0 0000 0",
                                 ibus.IReq, ibus.IAddr, Pc, CarryIn, Busy, Halted, RegWr, AluSave, m_pc, m_pc, m_carry);
                    end
                end
            end
        end
    endtask

    task automatic start_pulse();
        Start = 1'b1;
        step();
    endtask

    task automatic test_reset();
        Rst_n = 1'b1; Start = 1'b0; CarryOut = 1'b0;
        ibus.IAck = 1'b0; ibus.IData = 16'h0;
        prev_rst = 0; req_age = 0; ack_delay = 2; fixed_delay = 2; co_mode = 0;
        start_noise = 0; spur_ack = 0; rand_delay = 0; start_in_save = 0;
        #2 Rst_n = 1'b0;
        #1;
        checks++;
        if ({ibus.IReq, AluSave, Busy, Halted, CarryIn} !== 5'b0 || RegWr !== 16'h0 ||
            Opcode !== 16'h0 || Pc !== 8'h0 || ibus.IAddr !== 8'h0) begin
            errors++;
            $display("FAIL reset_values: IReq=%b AluSave=%b Busy=%b Halted=%b CarryIn=%b RegWr=%h Opcode=%h Pc=%h IAddr=%h, want all zero",
                     ibus.IReq, AluSave, Busy, Halted, CarryIn, RegWr, Opcode, Pc, ibus.IAddr);
        end
        do_reset();
        spur_ack = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ibus.IReq !== 1'b0 || Busy !== 1'b0 || Pc !== 8'h0 || Opcode !== 16'h0) begin
                errors++;
                $display("FAIL idle_hold: IReq=%b Busy=%b Pc=%h Opcode=%h, want 0 0 00 0000", ibus.IReq, Busy, Pc, Opcode);
            end
        end
        spur_ack = 0;
    endtask

    task automatic test_start_fetch();
        mem[0] = 16'h4213;
        mem[1] = 16'h1000;
        start_pulse();
        checks++;
        if (ibus.IReq !== 1'b1 || ibus.IAddr !== 8'h00 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL start_fetch: IReq=%b IAddr=%h Busy=%b, want 1 00 1", ibus.IReq, ibus.IAddr, Busy);
        end
    endtask

    task automatic test_alu_then_halt();
        bit h;
        run_prog(4, h);
        checks++;
        if (!h || Halted !== 1'b1 || Pc !== 8'h02) begin
            errors++;
            $display("FAIL alu_halt: halted=%b Halted=%b Pc=%h, want 1 1 02", h, Halted, Pc);
        end
    endtask

    task automatic test_resume();
        bit h;
        mem[2] = 16'h3000;
        mem[3] = 16'h1000;
        step();
        checks++;
        if (Halted !== 1'b1 || ibus.IReq !== 1'b0) begin
            errors++;
            $display("FAIL halted_hold: Halted=%b IReq=%b, want 1 0", Halted, ibus.IReq);
        end
        start_pulse();
        checks++;
        if (ibus.IReq !== 1'b1 || ibus.IAddr !== 8'h02 || Halted !== 1'b0) begin
            errors++;
            $display("FAIL resume: IReq=%b IAddr=%h Halted=%b, want 1 02 0", ibus.IReq, ibus.IAddr, Halted);
        end
        run_prog(4, h);
    endtask

    task automatic test_jmp();
        bit h;
        do_reset();
        mem[0]    = 16'h2A50;
        mem[8'hA5] = 16'h1000;
        start_pulse();
        run_prog(1, h);
        checks++;
        if (ibus.IAddr !== 8'hA5 || ibus.IReq !== 1'b1) begin
            errors++;
            $display("FAIL jmp_target: IAddr=%h IReq=%b, want a5 1", ibus.IAddr, ibus.IReq);
        end
        run_prog(2, h);
    endtask

    task automatic test_pc_wrap();
        bit h;
        do_reset();
        mem[0]     = 16'h2FF0;
        mem[8'hFF] = 16'h0000;
        start_pulse();
        run_prog(2, h);
        checks++;
        if (ibus.IAddr !== 8'h00 || ibus.IReq !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap: IAddr=%h IReq=%b, want 00 1", ibus.IAddr, ibus.IReq);
        end
    endtask

    task automatic test_carry();
        bit h;
        do_reset();
        mem[0] = 16'h4213;
        mem[1] = 16'h3000;
        mem[2] = 16'h1000;
        co_mode = 1;
        start_pulse();
        run_prog(1, h);
        checks++;
        if (CarryIn !== 1'b1) begin
            errors++;
            $display("FAIL carry_set: CarryIn=%b, want 1", CarryIn);
        end
        co_mode = 2;
        run_prog(1, h);
        checks++;
        if (CarryIn !== 1'b0) begin
            errors++;
            $display("FAIL carry_clear: CarryIn=%b, want 0", CarryIn);
        end
        run_prog(1, h);
        co_mode = 0;
    endtask

    task automatic test_start_in_save();
        bit h;
        do_reset();
        mem[0] = 16'h5A37;
        mem[1] = 16'h1000;
        start_in_save = 1;
        start_pulse();
        run_prog(3, h);
        start_in_save = 0;
        Start = 1'b0;
        checks++;
        if (!h || Pc !== 8'h02) begin
            errors++;
            $display("FAIL start_in_save: halted=%b Pc=%h, want 1 02", h, Pc);
        end
    endtask

    task automatic test_reset_mid_exec();
        int guard;
        do_reset();
        mem[0] = 16'h4213;
        start_pulse();
        guard = 0;
        while (!ack_this && guard < 20) begin
            step();
            guard++;
        end
        step(); step(); step();
        checks++;
        if (Busy !== 1'b1 || AluSave !== 1'b0 || RegWr !== 16'h0 || Opcode !== 16'h4213) begin
            errors++;
            $display("FAIL pre_reset_exec: Busy=%b AluSave=%b RegWr=%h Opcode=%h, want 1 0 0000 4213", Busy, AluSave, RegWr, Opcode);
        end
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({ibus.IReq, AluSave, Busy, Halted, CarryIn} !== 5'b0 || RegWr !== 16'h0 ||
            Opcode !== 16'h0 || Pc !== 8'h0) begin
            errors++;
            $display("FAIL async_reset: IReq=%b AluSave=%b Busy=%b Halted=%b CarryIn=%b RegWr=%h Opcode=%h Pc=%h, want all zero",
                     ibus.IReq, AluSave, Busy, Halted, CarryIn, RegWr, Opcode, Pc);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (RegWr !== 16'h0 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_wb: RegWr=%h Busy=%b, want 0000 0", RegWr, Busy);
            end
        end
        Rst_n = 1'b1;
    endtask

    task automatic test_random();
        bit h;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            int r;
            logic [15:0] w;
            r = int'($urandom_range(0, 99));
            w = 16'($urandom);
            if (r < 6)       w[15:12] = 4'd1;
            else if (r < 21) w[15:12] = 4'd0;
            else if (r < 36) w[15:12] = 4'd2;
            else if (r < 48) w[15:12] = 4'd3;
            else             w[15:12] = 4'($urandom_range(4, 15));
            mem[i] = w;
        end
        rand_delay = 1; spur_ack = 1; co_mode = 0;
        start_pulse();
        start_noise = 1;
        for (int blk = 0; blk < 12; blk++) begin
            run_prog(20, h);
            if (h) begin
                start_noise = 0;
                Start = 1'b0;
                step();
                checks++;
                if (Halted !== 1'b1 || Pc !== m_pc) begin
                    errors++;
                    $display("FAIL rand_halt_hold: Halted=%b Pc=%h, want 1 %h", Halted, Pc, m_pc);
                end
                start_pulse();
                checks++;
                if (ibus.IReq !== 1'b1 || ibus.IAddr !== m_pc) begin
                    errors++;
                    $display("FAIL rand_resume: IReq=%b IAddr=%h, want 1 %h", ibus.IReq, ibus.IAddr, m_pc);
                end
                start_noise = 1;
            end
        end
        start_noise = 0;
        Start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_fetch();
        test_alu_then_halt();
        test_resume();
        test_jmp();
        test_pc_wrap();
        test_carry();
        test_start_in_save();
        test_reset_mid_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
